// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: operands are shifted out LSB first, one bit per clock,
// through two half adders and a carry flop; the WIDTH+1 bit result lands in sum/cout.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             busy_nxt;
    logic             done_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] part;
    logic [CNT_W-1:0] cnt;
    logic             carry;

    logic             half_s;
    logic             half_c;
    logic             s;
    logic             carry_nxt;
    logic             last_bit;

    // Two half adders on the current bit pair plus the stored carry
    always_comb begin
        half_s    = a_sh[0] ^ b_sh[0];
        half_c    = a_sh[0] & b_sh[0];
        s         = half_s ^ carry;
        carry_nxt = half_c | (half_s & carry);
        last_bit  = (cnt == LAST_BIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_bit) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Flag values for the coming cycle, so busy/done come straight from flops
    always_comb begin
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state == RUN) && last_bit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh  <= '0;
            b_sh  <= '0;
            part  <= '0;
            cnt   <= '0;
            carry <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= 1'b0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_sh  <= a_sh >> 1;
                    b_sh  <= b_sh >> 1;
                    carry <= carry_nxt;
                    part  <= {s, part[WIDTH-1:1]};
                    // Counter parks on the last bit instead of wrapping
                    if (last_bit) begin
                        sum  <= {s, part[WIDTH-1:1]};
                        cout <= carry_nxt;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder at WIDTH=8: directed table, mid-run start/operand changes,
// mid-run reset, and random operands checked against plain a+b.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;

    int vectors;
    int miscompares;

    logic [W-1:0] last_sum;
    logic         last_cout;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] s;
        logic         c;
    } vec_t;

    vec_t tbl[7];

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One addition from the accepting edge through return to IDLE.
    // disturb: pulse start and scramble operands while the run is in progress.
    task automatic do_run(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W-1:0] es, input logic ec,
                          input bit disturb, input string name);
        int first_done;
        int pulses;
        logic [W-1:0] s_at;
        logic c_at;
        first_done = -1;
        pulses = 0;
        s_at = '0;
        c_at = 1'b0;
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        check({name, " busy_after_accept"}, 32'(busy), 32'd1);
        for (int n = 1; n <= W + 2; n++) begin
            if (disturb && n == 3) begin
                start = 1'b1;
                a = 8'hFF;
                b = 8'hFF;
            end
            if (disturb && n == 4) begin
                start = 1'b0;
                a = W'($urandom);
                b = W'($urandom);
            end
            tick();
            if (n == W - 1) begin
                check({name, " hold_sum"}, 32'(sum), 32'(last_sum));
                check({name, " hold_cout"}, 32'(cout), 32'(last_cout));
            end
            if (done) begin
                pulses++;
                if (first_done < 0) begin
                    first_done = n;
                    s_at = sum;
                    c_at = cout;
                end
            end
            if (n == W)     check({name, " busy_in_done"}, 32'(busy), 32'd1);
            if (n == W + 1) check({name, " busy_after"}, 32'(busy), 32'd0);
        end
        start = 1'b0;
        check({name, " latency"}, 32'(first_done), 32'(W));
        check({name, " pulses"}, 32'(pulses), 32'd1);
        check({name, " sum"}, 32'(s_at), 32'(es));
        check({name, " cout"}, 32'(c_at), 32'(ec));
        last_sum = es;
        last_cout = ec;
    endtask

    initial begin
        logic [W:0] ref_total;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        int saw_done;

        vectors = 0;
        miscompares = 0;
        last_sum = '0;
        last_cout = 1'b0;

        tbl[0] = '{a: 8'h00, b: 8'h00, s: 8'h00, c: 1'b0};
        tbl[1] = '{a: 8'hFF, b: 8'h01, s: 8'h00, c: 1'b1};
        tbl[2] = '{a: 8'hFF, b: 8'hFF, s: 8'hFE, c: 1'b1};
        tbl[3] = '{a: 8'hA5, b: 8'h5A, s: 8'hFF, c: 1'b0};
        tbl[4] = '{a: 8'h80, b: 8'h80, s: 8'h00, c: 1'b1};
        tbl[5] = '{a: 8'h0F, b: 8'h01, s: 8'h10, c: 1'b0};
        tbl[6] = '{a: 8'h7F, b: 8'h80, s: 8'hFF, c: 1'b0};

        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        tick();
        tick();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset sum", 32'(sum), 32'd0);
        check("reset cout", 32'(cout), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 7; i++)
            do_run(tbl[i].a, tbl[i].b, tbl[i].s, tbl[i].c, 1'b0, $sformatf("tbl%0d", i));

        // Start pulse and operand changes during RUN must be ignored
        tick();
        do_run(8'h12, 8'h34, 8'h46, 1'b0, 1'b1, "midrun_start");

        // Reset three edges into a run aborts it and clears the result
        a = 8'h80;
        b = 8'h80;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("rst sum", 32'(sum), 32'd0);
        check("rst cout", 32'(cout), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        saw_done = 0;
        for (int n = 0; n < W; n++) begin
            tick();
            if (done) saw_done++;
        end
        check("rst no_done", 32'(saw_done), 32'd0);
        last_sum = '0;
        last_cout = 1'b0;
        rst = 1'b0;
        do_run(8'h80, 8'h80, 8'h00, 1'b1, 1'b0, "post_rst");

        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            ref_total = {1'b0, ra} + {1'b0, rb};
            for (int g = 0; g < int'($urandom_range(0, 3)); g++) tick();
            do_run(ra, rb, ref_total[W-1:0], ref_total[W], 1'b0, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 The parameter shall be: WIDTH, default 8, operand width in bits (legal range 2 to 32).
REQ-002 The port clk shall be an input of 1 bit: the single clock, with rising-edge active.
REQ-003 The port rst shall be an input of 1 bit: the reset, asynchronous and active-high.
REQ-004 The port start shall be an input of 1 bit: the request to begin an addition, sampled on the rising edge of clk.
REQ-005 The ports a and b shall be inputs of WIDTH bits each: the operands, captured only on an accepted start.
REQ-006 The port busy shall be an output of 1 bit: high while an addition is in progress.
REQ-007 The port done shall be an output of 1 bit: a one-cycle pulse indicating that sum and cout hold a new result.
REQ-008 The ports sum (WIDTH bits) and cout (1 bit) shall be outputs: the registered result of a+b.
REQ-009 All outputs shall be driven directly from flops.

Function
REQ-010 The block shall be a bit-serial adder that processes operands LSB first, one bit per clock, using half-adder pairs plus a carry flop.
REQ-011 The state machine shall have exactly three states: IDLE, RUN and DONE.
REQ-012 In IDLE with start=1, the edge shall:
  - latch a and b into shift registers;
  - clear the carry flop and the bit counter;
  - move the state to RUN.
REQ-013 In IDLE with start=0, the block shall hold all state.
REQ-014 On each RUN edge, the block shall:
  - compute s = a_sh[0]^b_sh[0]^carry;
  - compute carry_next = (a_sh[0]&b_sh[0]) | ((a_sh[0]^b_sh[0])&carry);
  - shift a_sh and b_sh right by one;
  - shift s into the MSB of the partial-result register;
  - increment the counter.
REQ-015 When the RUN edge processes bit WIDTH-1, the same edge shall:
  - load sum with the completed partial result;
  - load cout with carry_next;
  - set done=1;
  - move the state to DONE.
REQ-016 Latency: if start is accepted on edge k, done shall be high from edge k+WIDTH until edge k+WIDTH+1, which is exactly one cycle.
REQ-017 In DONE, the next edge shall clear done and return the state to IDLE unconditionally.
REQ-018 busy shall be 1 in the RUN and DONE states and 0 in IDLE.
REQ-019 start shall be ignored in RUN and DONE, with no effect on the operation in progress; the minimum spacing between accepted starts shall be WIDTH+2 cycles.
REQ-020 Changes on a and b after the accepting edge shall not affect the result.
REQ-021 sum and cout shall hold the last completed result until the next completion, including through IDLE periods and the RUN of the next operation.
REQ-022 The arithmetic shall be unsigned; {cout,sum} shall equal a+b exactly (WIDTH+1 bits, no saturation).
REQ-023 The bit counter shall be ceil(log2(WIDTH)) bits wide and shall not wrap during RUN.

Reset
REQ-024 While rst=1, the block shall asynchronously force:
  - state to IDLE;
  - busy=0, done=0, sum=0, cout=0;
  - the carry flop, counter, shift registers and partial register to 0.
REQ-025 A reset asserted mid-RUN shall abort the operation: no done pulse shall occur and sum/cout shall read 0.
REQ-026 On the first rising edge after rst deasserts, start shall be sampled normally.

Verification (WIDTH=8)
REQ-027 The bench shall apply a=0x00, b=0x00, start for 1 cycle and require: busy=1 on the next cycle, then done high for 1 cycle 8 edges after acceptance, with sum=0x00 and cout=0.
REQ-028 The bench shall check the full carry chain: a=0xFF, b=0x01 shall produce sum=0x00, cout=1; a=0xFF, b=0xFF shall produce sum=0xFE, cout=1.
REQ-029 The bench shall check the no-carry case: a=0xA5, b=0x5A shall produce sum=0xFF, cout=0.
REQ-030 The bench shall run a=0x12, b=0x34, then pulse start with a=0xFF, b=0xFF during RUN and change a and b mid-run, and require a single done with sum=0x46, cout=0.
REQ-031 The bench shall assert rst 3 cycles into a run of a=0x80, b=0x80 and require: no done; sum=0x00 and cout=0 immediately; busy=0; a new run of a=0x80, b=0x80 after release producing sum=0x00, cout=1.
REQ-032 The bench shall run 200 random operand pairs and compare {cout,sum} against a+b, checking that done pulses exactly once per accepted start.
